// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the instruction-fetch and data ports.
// Optional `ARB_RR_EN selects round-robin conflict resolution instead of fixed data priority.
module sram_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_ce_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic [DATA_W-1:0] inst_data_o,
   output logic              inst_stall_o,
   input  logic              data_ce_i,
   input  logic              data_we_i,
   input  logic [3:0]        data_sel_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_data_i,
   output logic [DATA_W-1:0] data_data_o,
   output logic              data_stall_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_sel_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   localparam int LAT_W = 2;

   logic [1:0]       state;
   logic             owner;
   logic             is_wr;
   logic [LAT_W-1:0] lat_cnt;
   logic             grant_data;
   logic             any_req;
   logic             cap_en;

   assign any_req = inst_ce_i | data_ce_i;

`ifdef ARB_RR_EN
   logic last_owner;

   always_comb begin
      grant_data = data_ce_i;
      if (inst_ce_i && data_ce_i)
         grant_data = (last_owner == OWN_INST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_owner <= OWN_DATA;
      else if (state == S_IDLE && any_req)
         last_owner <= grant_data;
   end
`else
   always_comb begin
      grant_data = data_ce_i;
   end
`endif

   // Read data is sampled on the edge that enters DONE, i.e. the last cycle of the latency window.
   always_comb begin
      cap_en = 1'b0;
      if (state == S_ISSUE && !is_wr && RD_LAT == 1)
         cap_en = 1'b1;
      else if (state == S_WAIT && lat_cnt == LAT_W'(1))
         cap_en = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         owner      <= OWN_INST;
         is_wr      <= 1'b0;
         lat_cnt    <= '0;
         mem_ce_o   <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_sel_o  <= '0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  state    <= S_ISSUE;
                  mem_ce_o <= 1'b1;
                  owner    <= grant_data;
                  if (grant_data) begin
                     is_wr      <= data_we_i;
                     mem_we_o   <= data_we_i;
                     mem_sel_o  <= data_sel_i;
                     mem_addr_o <= data_addr_i;
                     mem_data_o <= data_data_i;
                  end else begin
                     is_wr      <= 1'b0;
                     mem_we_o   <= 1'b0;
                     mem_sel_o  <= '1;
                     mem_addr_o <= inst_addr_i;
                  end
               end
            end
            S_ISSUE: begin
               mem_ce_o <= 1'b0;
               mem_we_o <= 1'b0;
               if (is_wr) begin
                  state <= S_DONE;
               end else begin
                  lat_cnt <= LAT_W'(RD_LAT - 1);
                  state   <= (RD_LAT == 1) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (cap_en)
                  state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_data_o <= '0;
         data_data_o <= '0;
      end else if (cap_en) begin
         if (owner == OWN_DATA)
            data_data_o <= mem_data_i;
         else
            inst_data_o <= mem_data_i;
      end
   end

   assign inst_stall_o = rst_n & inst_ce_i & ~(state == S_DONE && owner == OWN_INST);
   assign data_stall_o = rst_n & data_ce_i & ~(state == S_DONE && owner == OWN_DATA);

endmodule
